// File: rtl/mac_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : mac_tx_arb
// Description : Two-port whole-frame arbiter feeding the MAC raw transmit port,
//               with back-pressure forwarding and stalled-source recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_arb #(
    parameter logic PRIO0      = 1'b0,
    parameter int   GAP_CYCLES = 2,
    parameter int   TIMEOUT    = 4096
) (
    input  logic        usr_clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic        sof0,
    input  logic        sof1,
    input  logic        eof0,
    input  logic        eof1,
    input  logic        we0,
    input  logic        we1,
    output logic        stop0,
    output logic        stop1,
    output logic [31:0] tx_raw_data,
    output logic        tx_raw_sof,
    output logic        tx_raw_we,
    input  logic        tx_raw_stop,
    output logic [1:0]  owner,
    output logic        timeout_err,
    output logic        proto_err
);

    localparam logic [15:0] c_TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  c_GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_pref1;
    logic        r_sof_seen;
    logic        r_dropping;
    logic [15:0] r_tcnt;
    logic [3:0]  r_gcnt;
    logic [31:0] r_tx_data;
    logic        r_tx_sof;
    logic        r_tx_we;
    logic        r_timeout_err;
    logic        r_proto_err;

    logic        w_grant;
    logic        w_own1;
    logic        w_we;
    logic        w_sof;
    logic        w_eof;
    logic [31:0] w_data;
    logic        w_fwd;
    logic        w_drop;
    logic        w_idle_inc;
    logic        w_tmo;
    logic        w_end;

    assign w_grant    = (r_state == S_GRANT0) || (r_state == S_GRANT1);
    assign w_own1     = (r_state == S_GRANT1);
    assign w_we       = w_grant & (w_own1 ? we1 : we0);
    assign w_sof      = w_own1 ? sof1 : sof0;
    assign w_eof      = w_own1 ? eof1 : eof0;
    assign w_data     = w_own1 ? data1 : data0;
    // A grant may only start forwarding on a sof word; anything before it is discarded.
    assign w_fwd      = w_we & (r_sof_seen | w_sof);
    assign w_drop     = w_we & ~w_fwd;
    assign w_idle_inc = w_grant & ~w_we & ~tx_raw_stop;
    assign w_tmo      = w_idle_inc & (r_tcnt == c_TO_LAST);
    assign w_end      = (w_fwd & w_eof) | w_tmo;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req0 && req1) begin
                    w_next = (PRIO0 || !r_pref1) ? S_GRANT0 : S_GRANT1;
                end else if (req0) begin
                    w_next = S_GRANT0;
                end else if (req1) begin
                    w_next = S_GRANT1;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (w_end) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gcnt == c_GAP_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge usr_clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pref1       <= 1'b0;
            r_sof_seen    <= 1'b0;
            r_dropping    <= 1'b0;
            r_tcnt        <= 16'd0;
            r_gcnt        <= 4'd0;
            r_tx_data     <= 32'd0;
            r_tx_sof      <= 1'b0;
            r_tx_we       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_tx_we       <= w_fwd;
            r_tx_sof      <= w_fwd & w_sof;
            r_timeout_err <= w_tmo;
            r_proto_err   <= w_drop & ~r_dropping;
            if (w_fwd) begin
                r_tx_data <= w_data;
            end
            if (w_grant && w_end) begin
                r_pref1 <= ~w_own1;
            end
            if (!w_grant) begin
                r_sof_seen <= 1'b0;
                r_dropping <= 1'b0;
                r_tcnt     <= 16'd0;
            end else begin
                if (w_fwd) begin
                    r_sof_seen <= 1'b1;
                end
                if (w_drop) begin
                    r_dropping <= 1'b1;
                end
                if (w_we) begin
                    r_tcnt <= 16'd0;
                end else if (w_idle_inc) begin
                    r_tcnt <= r_tcnt + 16'd1;
                end
            end
            if (r_state != S_GAP) begin
                r_gcnt <= 4'd0;
            end else begin
                r_gcnt <= r_gcnt + 4'd1;
            end
        end
    end

    assign gnt0        = (r_state == S_GRANT0);
    assign gnt1        = (r_state == S_GRANT1);
    assign owner       = {gnt1, gnt0};
    assign stop0       = gnt0 ? tx_raw_stop : 1'b1;
    assign stop1       = gnt1 ? tx_raw_stop : 1'b1;
    assign tx_raw_data = r_tx_data;
    assign tx_raw_sof  = r_tx_sof;
    assign tx_raw_we   = r_tx_we;
    assign timeout_err = r_timeout_err;
    assign proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_tx_arb
// Description : Scoreboard bench for mac_tx_arb: expected MAC words are queued
//               by the sources and popped by a monitor on every tx_raw_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_tx_arb;

    logic        usr_clk = 1'b0;
    logic        reset;
    logic        req0, req1, sof0, sof1, eof0, eof1, we0, we1, tx_raw_stop;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1, stop0, stop1, tx_raw_sof, tx_raw_we, timeout_err, proto_err;
    logic [31:0] tx_raw_data;
    logic [1:0]  owner;

    logic        p_req0, p_req1, p_we0, p_we1;
    logic        p_gnt0, p_gnt1, p_stop0, p_stop1, p_tx_sof, p_tx_we, p_tmo, p_perr;
    logic [31:0] p_tx_data;
    logic [1:0]  p_owner;

    always #5 usr_clk = ~usr_clk;

    mac_tx_arb #(.PRIO0(1'b0), .GAP_CYCLES(2), .TIMEOUT(16)) dut (
        .usr_clk(usr_clk), .reset(reset), .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1), .data0(data0), .data1(data1),
        .sof0(sof0), .sof1(sof1), .eof0(eof0), .eof1(eof1), .we0(we0), .we1(we1),
        .stop0(stop0), .stop1(stop1), .tx_raw_data(tx_raw_data), .tx_raw_sof(tx_raw_sof),
        .tx_raw_we(tx_raw_we), .tx_raw_stop(tx_raw_stop), .owner(owner),
        .timeout_err(timeout_err), .proto_err(proto_err)
    );

    mac_tx_arb #(.PRIO0(1'b1), .GAP_CYCLES(2), .TIMEOUT(16)) dut_prio (
        .usr_clk(usr_clk), .reset(reset), .req0(p_req0), .req1(p_req1),
        .gnt0(p_gnt0), .gnt1(p_gnt1), .data0(32'h0000_00A0), .data1(32'h0000_00B0),
        .sof0(1'b1), .sof1(1'b1), .eof0(1'b1), .eof1(1'b1), .we0(p_we0), .we1(p_we1),
        .stop0(p_stop0), .stop1(p_stop1), .tx_raw_data(p_tx_data), .tx_raw_sof(p_tx_sof),
        .tx_raw_we(p_tx_we), .tx_raw_stop(1'b0), .owner(p_owner),
        .timeout_err(p_tmo), .proto_err(p_perr)
    );

    typedef struct {
        logic [31:0] d;
        logic        s;
        int          c;
    } exp_t;

    exp_t q[$];
    int   olog[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_tmo = 0;
    int   n_perr = 0;
    logic [1:0] prev_own = 2'b00;

    always @(posedge usr_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: counts error pulses, logs grant order, and scores every MAC write.
    always @(negedge usr_clk) begin
        exp_t e;
        if (timeout_err === 1'b1) n_tmo++;
        if (proto_err === 1'b1) n_perr++;
        if (owner !== prev_own && owner !== 2'b00 && !$isunknown(owner)) olog.push_back(int'(owner));
        prev_own = owner;
        if (tx_raw_we === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got data %0h expected no write (t=%0t)", tx_raw_data, $time);
            end else begin
                e = q.pop_front();
                chk("tx_data", tx_raw_data, e.d);
                chk("tx_sof", 32'(tx_raw_sof), 32'(e.s));
                chk("tx_cycle", cyc, e.c);
            end
        end
    end

    task automatic step();
        @(posedge usr_clk);
        #1;
    endtask

    function automatic logic gnt_of(input int p);
        return (p != 0) ? gnt1 : gnt0;
    endfunction

    function automatic logic stop_of(input int p);
        return (p != 0) ? stop1 : stop0;
    endfunction

    task automatic drv(input int p, input logic we, input logic sof, input logic eof, input logic [31:0] d);
        if (p == 0) begin
            we0 = we; sof0 = sof; eof0 = eof; data0 = d;
        end else begin
            we1 = we; sof1 = sof; eof1 = eof; data1 = d;
        end
    endtask

    // Request, wait for the grant, send n_bad sof-less words then an n-word frame.
    task automatic send(input int p, input int n_bad, input int n, input bit last_eof,
                        input int stall_at, input int stall_len, input logic [31:0] base);
        int k = 0;
        if (p == 0) req0 = 1'b1; else req1 = 1'b1;
        while (!gnt_of(p) && k < 300) begin
            step();
            k++;
        end
        chk("grant_wait", 32'(gnt_of(p)), 32'd1);
        if (!gnt_of(p)) return;
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        for (int i = 0; i < n_bad; i++) begin
            drv(p, 1'b1, 1'b0, 1'b0, base + 32'h100 + 32'(i));
            step();
        end
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                tx_raw_stop = 1'b1;
                drv(p, 1'b0, 1'b0, 1'b0, 32'd0);
                #1;
                chk("stop_owner", 32'(stop_of(p)), 32'd1);
                chk("stop_other", 32'(stop_of(1 - p)), 32'd1);
                repeat (stall_len) step();
                chk("grant_held_in_stall", 32'(gnt_of(p)), 32'd1);
                tx_raw_stop = 1'b0;
            end
            drv(p, 1'b1, (i == 0), (last_eof && i == n - 1), base + 32'(i));
            q.push_back('{d: base + 32'(i), s: (i == 0), c: cyc + 1});
            step();
        end
        drv(p, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int p0;
        reset = 1'b1;
        req0 = 0; req1 = 0; tx_raw_stop = 0;
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        p_req0 = 0; p_req1 = 0; p_we0 = 0; p_we1 = 0;
        repeat (3) step();
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_tx_we", 32'(tx_raw_we), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_stop0", 32'(stop0), 1);
        chk("rst_stop1", 32'(stop1), 1);
        chk("rst_errs", {30'd0, timeout_err, proto_err}, 0);
        reset = 1'b0;

        // Fixed priority instance: port 0 keeps winning while it keeps requesting.
        p_req0 = 1; p_req1 = 1;
        k = 0;
        while (p_owner == 2'b00 && k < 20) begin step(); k++; end
        chk("prio_first", 32'(p_owner), 32'd1);
        p_we0 = 1; step(); p_we0 = 0;
        k = 0;
        while (p_owner == 2'b00 && k < 20) begin step(); k++; end
        chk("prio_second", 32'(p_owner), 32'd1);
        p_req0 = 0;
        p_we0 = 1; step(); p_we0 = 0;
        k = 0;
        while (p_owner == 2'b00 && k < 20) begin step(); k++; end
        chk("prio_then_port1", 32'(p_owner), 32'd2);
        p_req1 = 0;
        p_we1 = 1; step(); p_we1 = 0;

        // Single frame, grant latency and gap before the next grant.
        req0 = 1'b1;
        chk("gnt0_not_same_cycle", 32'(gnt0), 0);
        step();
        chk("gnt0_latency1", 32'(gnt0), 1);
        send(0, 0, 4, 1'b1, -1, 0, 32'hA000_0000);
        chk("gnt0_drop_after_eof", 32'(gnt0), 0);
        chk("owner_none_in_gap", 32'(owner), 0);
        req1 = 1'b1;
        step(); step();
        chk("gnt1_not_before_gap", 32'(gnt1), 0);
        step();
        chk("gnt1_after_gap", 32'(gnt1), 1);
        send(1, 0, 2, 1'b1, -1, 0, 32'hB000_0000);
        repeat (5) step();

        // Round-robin contention, three frames each.
        olog.delete();
        fork
            for (int f = 0; f < 3; f++) send(0, 0, 3, 1'b1, -1, 0, 32'hC000_0000 + 32'(f * 16));
            for (int f = 0; f < 3; f++) send(1, 0, 3, 1'b1, -1, 0, 32'hD000_0000 + 32'(f * 16));
        join
        repeat (5) step();
        chk("rr_count", olog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < olog.size()) chk("rr_order", olog[i], (i % 2 == 0) ? 1 : 2);
        end

        // Back-pressure longer than TIMEOUT must not time out.
        send(0, 0, 5, 1'b1, 2, 20, 32'hE000_0000);
        repeat (4) step();
        chk("no_timeout_stall", n_tmo, 0);

        // Timeout: port 1 stalls mid-frame while port 0 waits.
        send(1, 0, 3, 1'b0, -1, 0, 32'hF000_0000);
        req0 = 1'b1;
        k = 0;
        do begin step(); k++; end while (timeout_err !== 1'b1 && k < 30);
        chk("timeout_latency", k, 16);
        chk("gnt1_released_tmo", 32'(gnt1), 0);
        send(0, 0, 1, 1'b1, -1, 0, 32'h1000_0000);
        repeat (4) step();
        chk("timeout_pulses", n_tmo, 1);

        // Protocol: single-word frame, then a grant starting without sof.
        send(1, 0, 1, 1'b1, -1, 0, 32'h2000_0000);
        chk("gnt1_released_1word", 32'(gnt1), 0);
        p0 = n_perr;
        send(0, 2, 2, 1'b1, -1, 0, 32'h3000_0000);
        repeat (4) step();
        chk("proto_err_once", n_perr - p0, 1);

        // Reset mid-frame; pointer currently favours port 1, reset restores port 0.
        send(0, 0, 2, 1'b0, -1, 0, 32'h4000_0000);
        drv(0, 1'b1, 1'b0, 1'b0, 32'h4000_00FF);
        reset = 1'b1;
        step();
        chk("rstmid_gnt0", 32'(gnt0), 0);
        chk("rstmid_gnt1", 32'(gnt1), 0);
        chk("rstmid_tx_we", 32'(tx_raw_we), 0);
        chk("rstmid_owner", 32'(owner), 0);
        chk("rstmid_stops", {30'd0, stop1, stop0}, 3);
        reset = 1'b0;
        drv(0, 0, 0, 0, 0);
        req0 = 1'b1; req1 = 1'b1;
        step();
        chk("rst_rr_port0", 32'(owner), 1);
        send(0, 0, 1, 1'b1, -1, 0, 32'h5000_0000);
        send(1, 0, 1, 1'b1, -1, 0, 32'h6000_0000);
        repeat (5) step();
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
